ftdi_uart: RTL

- Memory-mapped 8N1 UART responder core on the CPU MMIO bus (core prefix 6'h03).
- Sits between the bus mux and the ftdi_txd/ftdi_rxd pins, replacing the single-bit bit-banged fake I/O path.
- Receives serial bytes into an RX FIFO and serialises CPU-written bytes onto txd.
- Exposes status, data and bit-rate registers through the standard cs/we/address/write_data/read_data/ready core interface.

---
 rtl/ftdi_uart_pkg.sv | 45 ++++
 rtl/ftdi_uart_fifo.sv | 59 +++++
 rtl/ftdi_uart.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ftdi_uart_pkg.sv
// ftdi_uart_pkg: shared constants and types for the ftdi_uart MMIO core.
// Holds the word-address map, the identification register values, the
// status-register bit positions, the default bit-rate divisor and the
// state encodings of the RX and TX engines.
package ftdi_uart_pkg;

    localparam logic [7:0] ADDR_NAME0     = 8'h00;
    localparam logic [7:0] ADDR_VERSION   = 8'h01;
    localparam logic [7:0] ADDR_DIVISOR   = 8'h08;
    localparam logic [7:0] ADDR_RX_STATUS = 8'h10;
    localparam logic [7:0] ADDR_RX_DATA   = 8'h11;
    localparam logic [7:0] ADDR_RX_CLEAR  = 8'h12;
    localparam logic [7:0] ADDR_TX_STATUS = 8'h20;
    localparam logic [7:0] ADDR_TX_DATA   = 8'h21;
    localparam logic [7:0] ADDR_LOOPBACK  = 8'h30;

    // ASCII "uart"
    localparam logic [31:0] NAME0_VALUE   = 32'h7561_7274;
    localparam logic [31:0] VERSION_VALUE = 32'h0000_0001;

    localparam int RX_NE_BIT  = 0;
    localparam int RX_OVR_BIT = 1;
    localparam int RX_FE_BIT  = 2;
    localparam int TX_RDY_BIT = 0;

    // 25 MHz / 115200 baud
    localparam int UART_DEFAULT_DIVISOR = 217;
    localparam int UART_MIN_DIVISOR     = 16;
    localparam int UART_RX_FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/ftdi_uart_fifo.sv
// ftdi_uart_fifo: synchronous byte FIFO for the UART receive path.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   push_i/data_i  write request and data; ignored while full
//   pop_i/data_o   read request and head entry; pop ignored while empty
//   full_o/empty_o occupancy flags
//   count_o        number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module ftdi_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (!do_push && do_pop) count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ftdi_uart.sv
// ftdi_uart: memory-mapped 8N1 UART responder core between the CPU MMIO bus
// mux and the ftdi_txd/ftdi_rxd pins. Received bytes land in an RX FIFO,
// CPU-written bytes are serialised on txd.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   rxd               serial input from host (asynchronous)
//   txd               serial output to host, idle high
//   cs, we, address   one-cycle access request (word address)
//   write_data        write data
//   read_data, ready  registered response, valid for the one cycle after cs
// Build option: define FTDI_UART_LOOPBACK_EN to add the LOOPBACK register
// (0x30 bit0), which feeds txd back into the RX synchroniser.
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a 1->0 edge on the synchronised line
//   RX_START | counting to start-bit midpoint, rejects glitches
//   RX_DATA  | sampling 8 data bits LSB first, one per divisor
//   RX_STOP  | sampling stop bit, push byte or flag framing error
// TX FSM
//   state    | meaning
//   TX_IDLE  | txd high, ready to accept a TX_DATA write
//   TX_START | driving start bit (0) for one divisor
//   TX_DATA  | driving 8 data bits LSB first
//   TX_STOP  | driving stop bit (1) for one divisor
module ftdi_uart
    import ftdi_uart_pkg::*;
#(
    parameter int DEFAULT_DIVISOR = UART_DEFAULT_DIVISOR,
    parameter int RX_FIFO_DEPTH   = UART_RX_FIFO_DEPTH,
    parameter int MIN_DIVISOR     = UART_MIN_DIVISOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    output logic        txd,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);
    localparam int CW = $clog2(RX_FIFO_DEPTH) + 1;
    localparam logic [15:0] DEF_DIV = 16'(DEFAULT_DIVISOR);
    localparam logic [15:0] MIN_DIV = 16'(MIN_DIVISOR);

    logic        rd_acc;
    logic        wr_acc;
    logic [15:0] div_q;
    logic        loopback_en;

    logic        ready_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    logic        rx_sync1_q;
    logic        rx_sync2_q;
    logic        rx_prev_q;
    logic        rx_src;
    logic        rx_fall;

    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q,   rx_cnt_d;
    logic [15:0] rx_div_q,   rx_div_d;
    logic [2:0]  rx_bit_q,   rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_term;
    logic        rx_push;
    logic        fe_set;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q,   tx_cnt_d;
    logic [15:0] tx_div_q,   tx_div_d;
    logic [2:0]  tx_bit_q,   tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q,      txd_d;
    logic        tx_term;
    logic        tx_ready;
    logic        tx_load;

    logic        ovr_q, ovr_d;
    logic        fe_q,  fe_d;
    logic        ovr_clr;
    logic        fe_clr;

    logic        fifo_pop;
    logic [7:0]  fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;

    logic        unused_wdata;

    assign rd_acc       = cs & ~we;
    assign wr_acc       = cs & we;
    assign unused_wdata = ^write_data[31:16];

    assign txd       = txd_q;
    assign ready     = ready_q;
    assign read_data = rdata_q;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= DEF_DIV;
        end else if (wr_acc && address == ADDR_DIVISOR) begin
            div_q <= (write_data[15:0] < MIN_DIV) ? MIN_DIV : write_data[15:0];
        end
    end

`ifdef FTDI_UART_LOOPBACK_EN
    logic loopback_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loopback_q <= 1'b0;
        end else if (wr_acc && address == ADDR_LOOPBACK) begin
            loopback_q <= write_data[0];
        end
    end

    assign loopback_en = loopback_q;
`else
    assign loopback_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read response: registered, zero unless a read hits a defined address
    // ------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        if (rd_acc) begin
            case (address)
                ADDR_NAME0:     rdata_d = NAME0_VALUE;
                ADDR_VERSION:   rdata_d = VERSION_VALUE;
                ADDR_DIVISOR:   rdata_d = {16'h0000, div_q};
                ADDR_RX_STATUS: begin
                    rdata_d[15:8]       = 8'(fifo_count);
                    rdata_d[RX_NE_BIT]  = ~fifo_empty;
                    rdata_d[RX_OVR_BIT] = ovr_q;
                    rdata_d[RX_FE_BIT]  = fe_q;
                end
                ADDR_RX_DATA:   rdata_d = {24'h000000, fifo_empty ? 8'h00 : fifo_rdata};
                ADDR_TX_STATUS: rdata_d[TX_RDY_BIT] = tx_ready;
`ifdef FTDI_UART_LOOPBACK_EN
                ADDR_LOOPBACK:  rdata_d[0] = loopback_en;
`endif
                default:        rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= cs;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser and edge detect; reset high so reset exit is no edge
    // ------------------------------------------------------------------
    assign rx_src  = loopback_en ? txd_q : rxd;
    assign rx_fall = rx_prev_q & ~rx_sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= rx_src;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM; divisor is captured at the start edge so a mid-frame
    // DIVISOR write only affects the next frame
    // ------------------------------------------------------------------
    assign rx_term = (rx_cnt_q == 16'd0);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_div_d   = div_q;
                    rx_cnt_d   = div_q >> 1;
                end
            end
            RX_START: begin
                if (rx_term) begin
                    if (rx_sync2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = 3'd0;
                        rx_cnt_d   = rx_div_q - 16'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_term) begin
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = rx_div_q - 16'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_term) begin
                    rx_state_d = RX_IDLE;
                    if (rx_sync2_q) rx_push = 1'b1;
                    else            fe_set  = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DEF_DIV;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO and sticky error flags (set wins over clear)
    // ------------------------------------------------------------------
    assign fifo_pop = rd_acc & (address == ADDR_RX_DATA) & ~fifo_empty;
    assign ovr_clr  = wr_acc & (address == ADDR_RX_CLEAR) & write_data[RX_OVR_BIT];
    assign fe_clr   = wr_acc & (address == ADDR_RX_CLEAR) & write_data[RX_FE_BIT];
    assign ovr_d    = (rx_push & fifo_full) | (ovr_q & ~ovr_clr);
    assign fe_d     = fe_set | (fe_q & ~fe_clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
            fe_q  <= fe_d;
        end
    end

    ftdi_uart_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_push),
        .data_i  (rx_shift_q),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ------------------------------------------------------------------
    // TX FSM; txd is registered so the start bit appears the cycle after
    // the TX_DATA write
    // ------------------------------------------------------------------
    assign tx_ready = (tx_state_q == TX_IDLE);
    assign tx_load  = wr_acc & (address == ADDR_TX_DATA) & tx_ready;
    assign tx_term  = (tx_cnt_q == 16'd0);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (tx_load) begin
                    tx_state_d = TX_START;
                    tx_shift_d = write_data[7:0];
                    tx_div_d   = div_q;
                    tx_cnt_d   = div_q - 16'd1;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_term) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_cnt_d   = tx_div_q - 16'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_term) begin
                    tx_cnt_d = tx_div_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_term) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DEF_DIV;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

endmodule
